// File: rtl/axi4_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_bridge_pkg
// Description : Shared AXI4 encodings and the read-arbiter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_bridge_pkg;

    localparam logic [1:0] AXI_RESP_OK    = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_arb_state_t;

endpackage : axi4_bridge_pkg
`default_nettype wire

// File: rtl/axi4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi4_rr_arbiter
// Description : Combinational request picker. Scans requests starting at
//               i_ptr and wrapping NM-1 -> 0; first active request wins.
//               With i_ptr tied to zero it degenerates to fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_rr_arbiter
    import axi4_bridge_pkg::*;
#(
    parameter int NM   = 4,
    parameter int IDXW = $clog2(NM)
) (
    input  logic [NM-1:0]   i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [NM-1:0]   o_gnt,
    output logic [IDXW-1:0] o_idx
);

    // Rotating first-one search from the pointer position
    always_comb begin
        int   k;
        logic found;
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NM; i++) begin
            k = int'(i_ptr) + i;
            if (k >= NM) k = k - NM;
            if (!found && i_req[k]) begin
                o_gnt[k] = 1'b1;
                o_idx    = IDXW'(k);
                found    = 1'b1;
            end
        end
    end

endmodule : axi4_rr_arbiter
`default_nettype wire

// File: rtl/axi4_s_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : axi4_s_rd_arb
// Description : Shares one AXI4 read slave between NM upstream masters with a
//               single outstanding burst. The AR of the winner is registered
//               and forwarded; R beats are routed back to the owner with zero
//               latency until RLAST.
//               Build option AXI4_RD_ARB_RR_EN: round-robin arbitration;
//               undefined: fixed priority (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_s_rd_arb
    import axi4_bridge_pkg::*;
#(
    parameter int NM   = 4,
    parameter int TAGW = 3,
    parameter int ADRW = 32,
    parameter int DATW = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NM*TAGW-1:0]   i_s_arid,
    input  logic [NM*ADRW-1:0]   i_s_araddr,
    input  logic [NM*8-1:0]      i_s_arlen,
    input  logic [NM*3-1:0]      i_s_arsize,
    input  logic [NM*2-1:0]      i_s_arburst,
    input  logic [NM-1:0]        i_s_arvalid,
    output logic [NM-1:0]        o_s_arready,
    output logic [TAGW-1:0]      o_s_rid,
    output logic [DATW-1:0]      o_s_rdata,
    output logic [1:0]           o_s_rresp,
    output logic                 o_s_rlast,
    output logic [NM-1:0]        o_s_rvalid,
    input  logic [NM-1:0]        i_s_rready,
    output logic [TAGW-1:0]      o_m_arid,
    output logic [ADRW-1:0]      o_m_araddr,
    output logic [7:0]           o_m_arlen,
    output logic [2:0]           o_m_arsize,
    output logic [1:0]           o_m_arburst,
    output logic                 o_m_arvalid,
    input  logic                 i_m_arready,
    input  logic [TAGW-1:0]      i_m_rid,
    input  logic [DATW-1:0]      i_m_rdata,
    input  logic [1:0]           i_m_rresp,
    input  logic                 i_m_rlast,
    input  logic                 i_m_rvalid,
    output logic                 o_m_rready,
    output logic [NM-1:0]        o_grant
);

    localparam int IDXW = $clog2(NM);

    rd_arb_state_t   r_state_q, r_state_d;
    logic [IDXW-1:0] r_grant_idx_q, r_grant_idx_d;
    logic [IDXW-1:0] r_rr_ptr_q, r_rr_ptr_d;
    logic [TAGW-1:0] r_arid_q, r_arid_d;
    logic [ADRW-1:0] r_araddr_q, r_araddr_d;
    logic [7:0]      r_arlen_q, r_arlen_d;
    logic [2:0]      r_arsize_q, r_arsize_d;
    logic [1:0]      r_arburst_q, r_arburst_d;

    logic [NM-1:0]   w_arb_gnt;
    logic [IDXW-1:0] w_arb_idx;
    logic [IDXW-1:0] w_arb_ptr;
    logic [NM-1:0]   w_owner_oh;
    logic            w_owner_rready;
    logic            w_last_beat;

`ifdef AXI4_RD_ARB_RR_EN
    assign w_arb_ptr = r_rr_ptr_q;
`else
    // Pointer still tracks the last owner; masked so the lowest index wins
    assign w_arb_ptr = r_rr_ptr_q & '0;
`endif

    axi4_rr_arbiter #(
        .NM   (NM),
        .IDXW (IDXW)
    ) u_arb (
        .i_req (i_s_arvalid),
        .i_ptr (w_arb_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

    assign w_owner_oh     = NM'(1) << r_grant_idx_q;
    assign w_owner_rready = i_s_rready[r_grant_idx_q];
    assign w_last_beat    = i_m_rvalid & w_owner_rready & i_m_rlast;

    // R payload is broadcast untouched; only RVALID is steered to the owner
    assign o_s_rid   = i_m_rid;
    assign o_s_rdata = i_m_rdata;
    assign o_s_rresp = i_m_rresp;
    assign o_s_rlast = i_m_rlast;

    assign o_m_arid    = r_arid_q;
    assign o_m_araddr  = r_araddr_q;
    assign o_m_arlen   = r_arlen_q;
    assign o_m_arsize  = r_arsize_q;
    assign o_m_arburst = r_arburst_q;

    // Next-state and handshake outputs for the IDLE/ADDR/DATA ownership cycle
    always_comb begin
        r_state_d     = r_state_q;
        r_grant_idx_d = r_grant_idx_q;
        r_rr_ptr_d    = r_rr_ptr_q;
        r_arid_d      = r_arid_q;
        r_araddr_d    = r_araddr_q;
        r_arlen_d     = r_arlen_q;
        r_arsize_d    = r_arsize_q;
        r_arburst_d   = r_arburst_q;
        o_s_arready   = '0;
        o_s_rvalid    = '0;
        o_m_arvalid   = 1'b0;
        o_m_rready    = 1'b0;
        o_grant       = '0;
        case (r_state_q)
            IDLE: begin
                if (|w_arb_gnt) begin
                    o_s_arready   = w_arb_gnt;
                    r_grant_idx_d = w_arb_idx;
                    r_arid_d      = i_s_arid[w_arb_idx*TAGW +: TAGW];
                    r_araddr_d    = i_s_araddr[w_arb_idx*ADRW +: ADRW];
                    r_arlen_d     = i_s_arlen[w_arb_idx*8 +: 8];
                    r_arsize_d    = i_s_arsize[w_arb_idx*3 +: 3];
                    r_arburst_d   = i_s_arburst[w_arb_idx*2 +: 2];
                    r_state_d     = ADDR;
                end
            end
            ADDR: begin
                o_m_arvalid = 1'b1;
                o_grant     = w_owner_oh;
                if (i_m_arready) r_state_d = DATA;
            end
            DATA: begin
                o_grant    = w_owner_oh;
                o_m_rready = w_owner_rready;
                o_s_rvalid = i_m_rvalid ? w_owner_oh : '0;
                if (w_last_beat) begin
                    r_state_d  = IDLE;
                    r_rr_ptr_d = (r_grant_idx_q == IDXW'(NM - 1)) ? '0
                                                                   : r_grant_idx_q + 1'b1;
                end
            end
            default: r_state_d = IDLE;
        endcase
    end

    // State and AR holding registers; reset abandons any burst in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q     <= IDLE;
            r_grant_idx_q <= '0;
            r_rr_ptr_q    <= '0;
            r_arid_q      <= '0;
            r_araddr_q    <= '0;
            r_arlen_q     <= '0;
            r_arsize_q    <= '0;
            r_arburst_q   <= '0;
        end else begin
            r_state_q     <= r_state_d;
            r_grant_idx_q <= r_grant_idx_d;
            r_rr_ptr_q    <= r_rr_ptr_d;
            r_arid_q      <= r_arid_d;
            r_araddr_q    <= r_araddr_d;
            r_arlen_q     <= r_arlen_d;
            r_arsize_q    <= r_arsize_d;
            r_arburst_q   <= r_arburst_d;
        end
    end

endmodule : axi4_s_rd_arb
`default_nettype wire
